// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states, per-cycle
// sequencing actions, default reset vector and PC step.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // What the sequencer does with its fetch state on the coming clock edge.
  typedef enum logic [2:0] {
    ACT_ADVANCE,
    ACT_HOLD,
    ACT_REDIRECT,
    ACT_HALT,
    ACT_FREEZE
  } action_e;

  localparam logic [15:0] RESET_VECTOR_DEFAULT = 16'h0000;
  localparam logic [15:0] PC_STEP              = 16'd2;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bundle between the sequencer (master) and decode/execute plus
// the synchronous-read instruction memory (slave).
interface fetch_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             stall;
  logic             br_taken;
  logic [15:0]      br_target;
  logic             jmp;
  logic [15:0]      jmp_target;
  logic             halt;
  logic [15:0]      pc;
  logic             ir_valid;
  logic [15:0]      ir_pc;
  logic [15:0]      ir_pcp2;
  logic             flush_id;
  logic             halted;
  logic             misalign_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    input  stall, br_taken, br_target, jmp, jmp_target, halt,
    output pc, ir_valid, ir_pc, ir_pcp2, flush_id, halted, misalign_err, stall_cycles
  );

  modport slave (
    output stall, br_taken, br_target, jmp, jmp_target, halt,
    input  pc, ir_valid, ir_pc, ir_pcp2, flush_id, halted, misalign_err, stall_cycles
  );
endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: redirect/halt/stall/advance priority and
// the even-address fix-up of redirect targets.
module fetch_next_pc
  import fetch_sequencer_pkg::*;
(
  input  state_e      i_state,
  input  logic [15:0] i_pc,
  input  logic        i_stall,
  input  logic        i_br_taken,
  input  logic [15:0] i_br_target,
  input  logic        i_jmp,
  input  logic [15:0] i_jmp_target,
  input  logic        i_halt,
  output action_e     o_action,
  output logic [15:0] o_next_pc,
  output logic        o_misalign
);

  logic [15:0] w_target;

  // NOTE: every output gets a default before the case so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    o_action   = ACT_FREEZE;
    o_next_pc  = i_pc;
    o_misalign = 1'b0;
    w_target   = i_br_taken ? i_br_target : i_jmp_target;

    unique case (i_state)
      ST_BOOT: begin
        o_action  = ACT_ADVANCE;
        o_next_pc = i_pc + PC_STEP;
      end
      ST_RUN: begin
        if (i_br_taken || i_jmp) begin
          o_action   = ACT_REDIRECT;
          o_next_pc  = {w_target[15:1], 1'b0};
          o_misalign = w_target[0];
        end else if (i_halt) begin
          o_action = ACT_HALT;
        end else if (i_stall) begin
          o_action = ACT_HOLD;
        end else begin
          o_action  = ACT_ADVANCE;
          o_next_pc = i_pc + PC_STEP;
        end
      end
      default: o_action = ACT_FREEZE;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, the instruction-valid tag aligned
// to a one-cycle-latency memory, the misalignment flag and stall counter.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master bus
);

  state_e           r_state;
  state_e           w_state_next;
  logic [15:0]      r_pc;
  logic             r_ir_valid;
  logic [15:0]      r_ir_pc;
  logic [15:0]      r_ir_pcp2;
  logic             r_misalign;
  logic [CNT_W-1:0] r_stall_cycles;

  action_e          w_action;
  logic [15:0]      w_next_pc;
  logic             w_misalign;
  logic             w_count_stall;

  fetch_next_pc u_next_pc (
    .i_state      (r_state),
    .i_pc         (r_pc),
    .i_stall      (bus.stall),
    .i_br_taken   (bus.br_taken),
    .i_br_target  (bus.br_target),
    .i_jmp        (bus.jmp),
    .i_jmp_target (bus.jmp_target),
    .i_halt       (bus.halt),
    .o_action     (w_action),
    .o_next_pc    (w_next_pc),
    .o_misalign   (w_misalign)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (w_action)
      ACT_ADVANCE, ACT_HOLD, ACT_REDIRECT: w_state_next = ST_RUN;
      ACT_HALT:                            w_state_next = ST_HALT;
      default:                             w_state_next = r_state;
    endcase
  end

  // A stall cycle is counted even if halt wins over it; only redirects mask it.
  assign w_count_stall = (r_state == ST_RUN) && bus.stall && !bus.br_taken && !bus.jmp;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_BOOT;
      r_pc           <= RESET_VECTOR;
      r_ir_valid     <= 1'b0;
      r_ir_pc        <= 16'h0000;
      r_ir_pcp2      <= 16'h0000;
      r_misalign     <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_next_pc;
      unique case (w_action)
        ACT_ADVANCE: begin
          r_ir_valid <= 1'b1;
          r_ir_pc    <= r_pc;
          r_ir_pcp2  <= r_pc + PC_STEP;
        end
        ACT_REDIRECT, ACT_HALT: r_ir_valid <= 1'b0;
        default: ;
      endcase
      if (w_misalign) r_misalign <= 1'b1;
      if (w_count_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign bus.pc           = r_pc;
  assign bus.ir_valid     = r_ir_valid;
  assign bus.ir_pc        = r_ir_pc;
  assign bus.ir_pcp2      = r_ir_pcp2;
  assign bus.flush_id     = (r_state == ST_RUN) && bus.br_taken;
  assign bus.halted       = (r_state == ST_HALT);
  assign bus.misalign_err = r_misalign;
  assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a driver pushes model-predicted
// per-cycle outputs, an independent monitor pops and compares them.
module tb_fetch_sequencer;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  fetch_sequencer_if #(.CNT_W(CNT_W)) bus ();

  fetch_sequencer #(.RESET_VECTOR(16'h0000), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic        ir_valid;
    logic [15:0] ir_pc;
    logic [15:0] ir_pcp2;
    logic        flush_id;
    logic        halted;
    logic        misalign_err;
    int          stall_cycles;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: architectural view of the fetch unit.
  bit          m_booting;
  bit          m_halted;
  logic [15:0] m_pc;
  bit          m_valid;
  logic [15:0] m_ir_pc;
  logic [15:0] m_ir_pcp2;
  bit          m_mis;
  int          m_stalls;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_booting = 1; m_halted = 0; m_pc = 16'h0000; m_valid = 0;
    m_ir_pc = 16'h0000; m_ir_pcp2 = 16'h0000; m_mis = 0; m_stalls = 0;
  endtask

  task automatic model_step(input bit st, input bit br, input logic [15:0] bt,
                            input bit j, input logic [15:0] jt, input bit h);
    logic [15:0] t;
    if (m_booting) begin
      m_valid = 1; m_ir_pc = m_pc; m_ir_pcp2 = m_pc + 16'd2; m_pc = m_pc + 16'd2;
      m_booting = 0;
    end else if (m_halted) begin
      // frozen until reset
    end else if (br || j) begin
      t = br ? bt : jt;
      if (t[0]) m_mis = 1;
      m_pc = t & 16'hFFFE;
      m_valid = 0;
    end else begin
      if (st && m_stalls < CNT_MAX) m_stalls++;
      if (h) begin
        m_halted = 1; m_valid = 0;
      end else if (!st) begin
        m_ir_pc = m_pc; m_ir_pcp2 = m_pc + 16'd2; m_pc = m_pc + 16'd2; m_valid = 1;
      end
    end
  endtask

  task automatic step(input bit rst_n, input bit st, input bit br, input logic [15:0] bt,
                      input bit j, input logic [15:0] jt, input bit h);
    exp_t e;
    @(negedge clk);
    #1;
    reset = rst_n; bus.stall = st; bus.br_taken = br; bus.br_target = bt;
    bus.jmp = j; bus.jmp_target = jt; bus.halt = h;
    if (!rst_n) model_reset();
    e.pc = m_pc; e.ir_valid = m_valid; e.ir_pc = m_ir_pc; e.ir_pcp2 = m_ir_pcp2;
    e.flush_id = rst_n && !m_booting && !m_halted && br;
    e.halted = m_halted; e.misalign_err = m_mis; e.stall_cycles = m_stalls;
    sb.push_back(e);
    if (rst_n) model_step(st, br, bt, j, jt, h);
  endtask

  task automatic idle();
    step(1, 0, 0, 16'h0, 0, 16'h0, 0);
  endtask

  // Spot checks against fixed expectations, sampled with the monitor.
  task automatic spot(input string name, input logic [31:0] act_sel, input logic [31:0] req);
    check(name, act_sel, req);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pc",           32'(bus.pc),           32'(e.pc));
        check("ir_valid",     32'(bus.ir_valid),     32'(e.ir_valid));
        if (e.ir_valid) begin
          check("ir_pc",      32'(bus.ir_pc),        32'(e.ir_pc));
          check("ir_pcp2",    32'(bus.ir_pcp2),      32'(e.ir_pcp2));
        end
        check("flush_id",     32'(bus.flush_id),     32'(e.flush_id));
        check("halted",       32'(bus.halted),       32'(e.halted));
        check("misalign_err", 32'(bus.misalign_err), 32'(e.misalign_err));
        check("stall_cycles", 32'(bus.stall_cycles), 32'(e.stall_cycles));
      end
    end
  end

  initial begin : driver
    int budget;
    reset = 1'b0; bus.stall = 0; bus.br_taken = 0; bus.br_target = 0;
    bus.jmp = 0; bus.jmp_target = 0; bus.halt = 0;
    model_reset();

    step(0, 0, 0, 16'h0, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 0, 16'h0, 0);
    idle(); #1 spot("boot_pc", 32'(bus.pc), 32'h0000);
            spot("boot_valid", 32'(bus.ir_valid), 32'h0);
    idle(); #1 spot("run_ir_pc0", 32'(bus.ir_pc), 32'h0000);
    idle(); #1 spot("run_ir_pc1", 32'(bus.ir_pc), 32'h0002);
    idle(); #1 spot("run_pc3", 32'(bus.pc), 32'h0006);
    step(1, 0, 1, 16'h0040, 1, 16'h0080, 0); #1 spot("br_flush", 32'(bus.flush_id), 32'h1);
    idle(); #1 spot("br_pc", 32'(bus.pc), 32'h0040);
            spot("br_bubble", 32'(bus.ir_valid), 32'h0);
    idle(); #1 spot("br_after_pc", 32'(bus.pc), 32'h0042);
    step(1, 0, 0, 16'h0, 1, 16'h0010, 0);
    repeat (3) step(1, 1, 0, 16'h0, 0, 16'h0, 0);
    step(1, 1, 0, 16'h0, 1, 16'h0031, 0); #1 spot("stall_cnt", 32'(bus.stall_cycles), 32'd3);
                                              spot("stall_pc", 32'(bus.pc), 32'h0010);
    step(1, 0, 1, 16'hFFFC, 0, 16'h0, 0); #1 spot("misalign_pc", 32'(bus.pc), 32'h0030);
                                              spot("misalign_err", 32'(bus.misalign_err), 32'h1);
    idle(); #1 spot("wrap_pc0", 32'(bus.pc), 32'hFFFC);
    idle(); #1 spot("wrap_pc1", 32'(bus.pc), 32'hFFFE);
    step(1, 0, 0, 16'h0, 1, 16'h0020, 0); #1 spot("wrap_pcp2", 32'(bus.ir_pcp2), 32'h0000);
                                              spot("wrap_pc2", 32'(bus.pc), 32'h0000);
    step(1, 1, 0, 16'h0, 0, 16'h0, 1);
    step(1, 0, 1, 16'h0100, 1, 16'h0200, 0); #1 spot("halted", 32'(bus.halted), 32'h1);
                                                 spot("halt_pc", 32'(bus.pc), 32'h0020);
                                                 spot("halt_noflush", 32'(bus.flush_id), 32'h0);
    step(1, 0, 1, 16'h0100, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 0, 16'h0, 0); #1 spot("rst_halted", 32'(bus.halted), 32'h0);
                                           spot("rst_pc", 32'(bus.pc), 32'h0000);
                                           spot("rst_mis", 32'(bus.misalign_err), 32'h0);
    idle();
    repeat (20) step(1, 1, 0, 16'h0, 0, 16'h0, 0);
    idle(); #1 spot("stall_sat", 32'(bus.stall_cycles), 32'(CNT_MAX));

    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(199) != 0), ($urandom_range(3) == 0),
           ($urandom_range(9) == 0), 16'($urandom),
           ($urandom_range(9) == 0), 16'($urandom),
           ($urandom_range(39) == 0));
    end
    idle();

    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #3;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: RESET_VECTOR, default 16'h0000, PC loaded on reset.
REQ-002 Parameter: CNT_W, default 16, width of the stall-cycle counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  decode cannot accept an instruction this cycle.
REQ-006 br_taken  input  1  execute-stage branch resolved taken.
REQ-007 br_target  input  16  branch destination.
REQ-008 jmp  input  1  decode-stage unconditional jump.
REQ-009 jmp_target  input  16  jump destination.
REQ-010 halt  input  1  halt request from decode.
REQ-011 pc  output  16  fetch address driven to synchronous-read instruction memory.
REQ-012 ir_valid  output  1  instruction memory output this cycle is a live instruction.
REQ-013 ir_pc / ir_pcp2  output  16 each  address of the instruction on ir, and that address +2.
REQ-014 flush_id  output  1  squash the instruction currently in decode.
REQ-015 halted  output  1  sequencer is in HALT.
REQ-016 misalign_err  output  1  sticky flag; an odd redirect target was received.
REQ-017 stall_cycles  output  CNT_W  saturating count of RUN cycles with stall=1.

Function
REQ-018 States: BOOT, RUN, HALT; BOOT entered on reset.
REQ-019 BOOT lasts one cycle: pc=RESET_VECTOR, ir_valid=0, then RUN with pc advancing to RESET_VECTOR+2.
REQ-020 Next-PC priority in RUN: br_taken > jmp > halt > stall > pc+2.
REQ-021 br_taken: pc<=br_target, flush_id=1 combinationally same cycle, ir_valid=0 next cycle; jmp and stall ignored.
REQ-022 jmp (no br_taken): pc<=jmp_target, ir_valid=0 next cycle, flush_id=0.
REQ-023 Redirect overrides stall; stall overrides only sequential increment.
REQ-024 stall (no redirect): pc, ir_valid, ir_pc, ir_pcp2 all hold.
REQ-025 Normal advance: pc<=pc+2; ir_valid<=1; ir_pc<=pc; ir_pcp2<=pc+2 (1-cycle memory latency alignment).
REQ-026 All PC arithmetic is modulo 2^16: 16'hFFFE+2 = 16'h0000, no error.
REQ-027 Redirect target with bit0=1: bit0 forced to 0 before loading pc, misalign_err set and held until reset.
REQ-028 halt (no redirect): enter HALT next cycle; pc frozen; ir_valid=0; halted=1; exit only by reset.
REQ-029 br_taken in same cycle as halt: redirect wins, no HALT entry.
REQ-030 In HALT all redirect, stall and halt inputs are ignored.
REQ-031 stall_cycles increments in RUN when stall=1 and no redirect, saturates at all-ones.

Reset
REQ-032 reset low asynchronously forces: state=BOOT, pc=RESET_VECTOR, ir_valid=0, ir_pc=0, ir_pcp2=0, flush_id=0, halted=0, misalign_err=0, stall_cycles=0.
REQ-033 Reset asserted mid-redirect or in HALT discards all pending state; release always restarts at BOOT.

Structure
REQ-034 Shared package holds state encoding (BOOT/RUN/HALT), RESET_VECTOR default and PC_STEP=2.
REQ-035 One combinational sub-module fetch_next_pc implements the priority mux and alignment fix-up; all registers live in fetch_sequencer.

Verification
REQ-036 Reset release, no inputs -> pc 0000,0002,0004,0006; ir_valid 0,1,1,1; ir_pc 0000,0002 on cycles 2,3.
REQ-037 At pc=0008 assert br_taken, br_target=0040, and jmp=1, jmp_target=0080 -> flush_id=1 that cycle, next pc=0040, ir_valid=0, then pc=0042 with ir_valid=1.
REQ-038 stall=1 for 3 cycles at pc=0010 -> pc holds 0010, stall_cycles=3; with jmp_target=0031 during stall -> pc=0030, misalign_err=1.
REQ-039 Preload pc to FFFC via br_target -> pc sequence FFFC, FFFE, 0000, ir_pcp2 for FFFE = 0000.
REQ-040 halt=1 at pc=0020 -> halted=1 next cycle, pc frozen at 0020, later br_taken ignored; reset low mid-HALT -> all outputs to reset values immediately, BOOT after release.
